stack_pusher: RTL and testbench

//  Write-side counterpart of the PC/flags pop accumulator: on CALL/INT, serialises the
//  32-bit return PC (and, for INT, the 3-bit CCR flags) into 16-bit words on the

---
 rtl/stack_pusher.sv | 115 +++++++++++
 tb/tb_stack_pusher.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/stack_pusher.sv
// stack_pusher: serialises a return PC (and, for interrupts, the CCR flags)
// onto the data-memory write port as DATA_W-bit words, post-decrementing SP
// once per accepted word. Push order is flags, PC high, PC low, so that the
// low half of the PC ends up on top of the stack for the pop side.
module stack_pusher #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 32,
    parameter int FLAG_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                push_flags,
    input  logic [2*DATA_W-1:0] pc_in,
    input  logic [FLAG_W-1:0]   flags_in,
    input  logic [ADDR_W-1:0]   sp_in,
    input  logic                mem_stall,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [1:0]          phase,
    output logic                busy,
    output logic                sp_we,
    output logic [ADDR_W-1:0]   sp_out,
    output logic                done
);

    // Low two bits of the write states match the phase codes shared with the
    // pop side; IDLE and FIN both read as phase 00.
    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_PC_LO = 3'b001,
        S_PC_HI = 3'b010,
        S_FLAGS = 3'b011,
        S_FIN   = 3'b100
    } state_t;

    state_t              state, state_n;
    logic [2*DATA_W-1:0] pc_r;
    logic [FLAG_W-1:0]   fl_r;
    logic [ADDR_W-1:0]   sp_r;
    logic                wr_state;

    // State register; reset aborts any sequence in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Capture operands on an accepted start, then walk SP down once per
    // word that memory actually accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= '0;
            fl_r <= '0;
            sp_r <= '0;
        end else if (state == S_IDLE && start) begin
            pc_r <= pc_in;
            fl_r <= flags_in;
            sp_r <= sp_in;
        end else if (wr_state && !mem_stall) begin
            sp_r <= sp_r - ADDR_W'(1);
        end
    end

    // Next-state and output decode. Outputs depend only on registered state
    // and captured operands, so nothing combinational leaks from the inputs.
    always_comb begin
        state_n   = state;
        wr_state  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        phase     = 2'b00;
        busy      = 1'b0;
        sp_we     = 1'b0;
        sp_out    = '0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_n = push_flags ? S_FLAGS : S_PC_HI;
            end
            S_FLAGS: begin
                wr_state  = 1'b1;
                mem_wdata = {{(DATA_W-FLAG_W){1'b0}}, fl_r};
                if (!mem_stall) state_n = S_PC_HI;
            end
            S_PC_HI: begin
                wr_state  = 1'b1;
                mem_wdata = pc_r[2*DATA_W-1:DATA_W];
                if (!mem_stall) state_n = S_PC_LO;
            end
            S_PC_LO: begin
                wr_state  = 1'b1;
                mem_wdata = pc_r[DATA_W-1:0];
                if (!mem_stall) state_n = S_FIN;
            end
            S_FIN: begin
                // Start is not sampled here: a request arriving now is dropped.
                sp_we   = 1'b1;
                sp_out  = sp_r;
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        if (wr_state) begin
            mem_we   = 1'b1;
            mem_addr = sp_r;
            phase    = state[1:0];
            busy     = 1'b1;
        end
    end

endmodule

// File: tb/tb_stack_pusher.sv
// Bench for stack_pusher: directed cases plus randomized push sequences,
// each checked against a word list built from the push-order rules.
module tb_stack_pusher;

    logic        clk;
    logic        rst;
    logic        start;
    logic        push_flags;
    logic [31:0] pc_in;
    logic [2:0]  flags_in;
    logic [31:0] sp_in;
    logic        mem_stall;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  phase;
    logic        busy;
    logic        sp_we;
    logic [31:0] sp_out;
    logic        done;

    int checks = 0;
    int errors = 0;

    stack_pusher #(.DATA_W(16), .ADDR_W(32), .FLAG_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .push_flags(push_flags),
        .pc_in(pc_in), .flags_in(flags_in), .sp_in(sp_in), .mem_stall(mem_stall),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .phase(phase),
        .busy(busy), .sp_we(sp_we), .sp_out(sp_out), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".we"}, mem_we, 1'b0);
        chk({tag, ".busy"}, busy, 1'b0);
        chk({tag, ".phase"}, phase, 2'b00);
        chk({tag, ".done"}, done, 1'b0);
        chk({tag, ".sp_we"}, sp_we, 1'b0);
    endtask

    // One full push sequence. Called at a negedge with the DUT idle.
    // smode: 0 no stall, 1 random stalls, 2 two stall cycles during PC_HI.
    task automatic run_seq(input bit intr, input logic [31:0] pc, input logic [2:0] fl,
                           input logic [31:0] sp, input int smode);
        logic [31:0] ea[$];
        logic [15:0] ed[$];
        logic [1:0]  ep[$];
        logic [31:0] a;
        int          idx, n, cyc, hi_st;
        bit          st;
        a = sp;
        if (intr) begin
            ea.push_back(a); ed.push_back({13'b0, fl}); ep.push_back(2'b11); a = a - 1;
        end
        ea.push_back(a); ed.push_back(pc[31:16]); ep.push_back(2'b10); a = a - 1;
        ea.push_back(a); ed.push_back(pc[15:0]);  ep.push_back(2'b01); a = a - 1;
        n = ea.size();
        start = 1'b1; push_flags = intr; pc_in = pc; flags_in = fl; sp_in = sp;
        mem_stall = (smode == 1) ? 1'($urandom) : 1'b0;
        @(negedge clk);
        idx = 0; cyc = 0; hi_st = 0;
        while (1) begin
            cyc++;
            checks++;
            assert (cyc <= 40) else begin
                errors++;
                $error("FAIL timeout: observed cycles=%0d expected<=40", cyc);
            end
            if (cyc > 40) break;
            if (idx < n) begin
                chk("w.we", mem_we, 1'b1);
                chk("w.addr", mem_addr, ea[idx]);
                chk("w.data", mem_wdata, ed[idx]);
                chk("w.phase", phase, ep[idx]);
                chk("w.busy", busy, 1'b1);
                chk("w.done", done, 1'b0);
                chk("w.sp_we", sp_we, 1'b0);
                // Inputs wiggle while busy; the captured operands must not move.
                start = 1'($urandom); push_flags = 1'($urandom);
                pc_in = $urandom; flags_in = 3'($urandom); sp_in = $urandom;
                case (smode)
                    1:       st = ($urandom_range(0, 2) == 0);
                    2:       st = (ep[idx] == 2'b10 && hi_st < 2);
                    default: st = 1'b0;
                endcase
                if (st && ep[idx] == 2'b10) hi_st++;
                mem_stall = st;
                if (!st) idx++;
            end else begin
                chk("f.done", done, 1'b1);
                chk("f.sp_we", sp_we, 1'b1);
                chk("f.sp_out", sp_out, a);
                chk("f.we", mem_we, 1'b0);
                chk("f.busy", busy, 1'b0);
                chk("f.phase", phase, 2'b00);
                // A start seen during FIN must be dropped.
                start = 1'($urandom); mem_stall = 1'($urandom);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        chk_idle("post");
        start = 1'b0; mem_stall = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; push_flags = 1'b0; pc_in = '0; flags_in = '0;
        sp_in = '0; mem_stall = 1'b0;
        @(negedge clk);
        chk_idle("reset");
        chk("reset.addr", mem_addr, 32'h0);
        chk("reset.data", mem_wdata, 16'h0);
        chk("reset.sp_out", sp_out, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases from the block's intended use.
        run_seq(1'b0, 32'h0001_2345, 3'b000, 32'h0000_03FF, 0);
        run_seq(1'b1, 32'hABCD_0010, 3'b101, 32'h0000_03FF, 0);
        run_seq(1'b1, 32'hABCD_0010, 3'b101, 32'h0000_03FF, 2);
        run_seq(1'b0, 32'h1234_5678, 3'b000, 32'h0000_0000, 0);

        // Reset during PC_HI: outputs clear asynchronously, no completion.
        start = 1'b1; push_flags = 1'b0; pc_in = 32'hDEAD_BEEF; sp_in = 32'h50;
        @(negedge clk);
        start = 1'b0;
        chk("abort.we_before", mem_we, 1'b1);
        chk("abort.phase_before", phase, 2'b10);
        #1 rst = 1'b1;
        #1;
        chk_idle("abort");
        chk("abort.addr", mem_addr, 32'h0);
        chk("abort.data", mem_wdata, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_idle("abort.after");
        end

        // Start held high: second sequence begins right after the FIN/IDLE pair.
        start = 1'b1; push_flags = 1'b0; pc_in = 32'h1111_2222; sp_in = 32'h100;
        @(negedge clk);
        chk("b2b.a0", mem_addr, 32'h100);
        chk("b2b.d0", mem_wdata, 16'h1111);
        @(negedge clk);
        chk("b2b.a1", mem_addr, 32'hFF);
        sp_in = 32'h200; pc_in = 32'h3333_4444;
        @(negedge clk);
        chk("b2b.done", done, 1'b1);
        chk("b2b.sp_out", sp_out, 32'hFE);
        @(negedge clk);
        chk_idle("b2b.gap");
        @(negedge clk);
        start = 1'b0;
        chk("b2b.we2", mem_we, 1'b1);
        chk("b2b.a2", mem_addr, 32'h200);
        chk("b2b.d2", mem_wdata, 16'h3333);
        @(negedge clk);
        chk("b2b.a3", mem_addr, 32'h1FF);
        chk("b2b.d3", mem_wdata, 16'h4444);
        @(negedge clk);
        chk("b2b.done2", done, 1'b1);
        chk("b2b.sp_out2", sp_out, 32'h1FE);
        @(negedge clk);
        chk_idle("b2b.end");

        // Randomized sequences with random stalls; SP sometimes near zero to wrap.
        for (int t = 0; t < 40; t++) begin
            logic [31:0] sp;
            sp = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
            run_seq(1'($urandom), $urandom, 3'($urandom), sp, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
